// File: rtl/ct_l2c_data_sram_ctrl_pkg.sv
// Shared definitions for the L2 data-array SRAM access controller.
package ct_l2c_data_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2
  } l2c_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned LAT_CNT_W  = 3;

  // SRAM control pins when no access is in progress
  localparam logic CEN_IDLE  = 1'b1;
  localparam logic GWEN_IDLE = 1'b1;

endpackage

// File: rtl/ct_l2c_data_sram_ctrl_if.sv
// Request/response handshake and SRAM pin bundle for the L2 data-array controller.
interface ct_l2c_data_sram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 128
);

  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  init_done;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  // Requester plus SRAM macro side
  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, sram_q,
    input  req_rdy, rsp_vld, rsp_data, init_done,
    input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  // Controller side
  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, sram_q,
    output req_rdy, rsp_vld, rsp_data, init_done,
    output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

endinterface

// File: rtl/ct_l2c_data_sram_ctrl.sv
// L2 data-array single-port SRAM controller: optional zero-fill after reset,
// then one read or write per accepted request with registered SRAM pins.
module ct_l2c_data_sram_ctrl
  import ct_l2c_data_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned RD_LAT     = 1,
  parameter bit          INIT_EN    = 1'b1
) (
  input logic                   forever_cpuclk,
  input logic                   cpurst,
  ct_l2c_data_sram_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_chk
    $error("ct_l2c_data_sram_ctrl: RD_LAT must be within 1..4");
  end

  l2c_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_end_q, init_end_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
  logic                  sram_cen_q, sram_cen_d;
  logic                  sram_gwen_q, sram_gwen_d;
  logic [DATA_WIDTH-1:0] sram_wen_q, sram_wen_d;
  logic [DATA_WIDTH-1:0] sram_d_q, sram_d_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  init_done_q, init_done_d;

  // State and output registers
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_end_q  <= 1'b0;
      lat_cnt_q   <= '0;
      sram_a_q    <= '0;
      sram_cen_q  <= CEN_IDLE;
      sram_gwen_q <= GWEN_IDLE;
      sram_wen_q  <= '1;
      sram_d_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_end_q  <= init_end_d;
      lat_cnt_q   <= lat_cnt_d;
      sram_a_q    <= sram_a_d;
      sram_cen_q  <= sram_cen_d;
      sram_gwen_q <= sram_gwen_d;
      sram_wen_q  <= sram_wen_d;
      sram_d_q    <= sram_d_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_data_q  <= rsp_data_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_end_d  = init_end_q;
    lat_cnt_d   = lat_cnt_q;
    sram_a_d    = sram_a_q;
    sram_cen_d  = CEN_IDLE;
    sram_gwen_d = GWEN_IDLE;
    sram_wen_d  = '1;
    sram_d_d    = sram_d_q;
    rsp_vld_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    init_done_d = init_done_q;

    case (state_q)
      ST_INIT: begin
        if (!INIT_EN || init_end_q) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          sram_cen_d  = 1'b0;
          sram_gwen_d = 1'b0;
          sram_wen_d  = '0;
          sram_a_d    = init_cnt_q;
          sram_d_d    = '0;
          // Counter parks on the last address; the flag spends one cycle
          // letting the final write complete before traffic is accepted.
          if (init_cnt_q == ADDR_LAST) begin
            init_end_d = 1'b1;
          end else begin
            init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end

      ST_IDLE: begin
        if (bus.req_vld) begin
          sram_cen_d = 1'b0;
          sram_a_d   = bus.req_addr;
          if (bus.req_wr) begin
            sram_gwen_d = 1'b0;
            sram_wen_d  = ~bus.req_wmask;
            sram_d_d    = bus.req_wdata;
          end else begin
            state_d   = ST_RD_WAIT;
            lat_cnt_d = LAT_CNT_W'(RD_LAT);
          end
        end
      end

      ST_RD_WAIT: begin
        // Count reaches zero in the cycle Q is valid
        if (lat_cnt_q == '0) begin
          rsp_data_d = bus.sram_q;
          rsp_vld_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  assign bus.req_rdy   = (state_q == ST_IDLE);
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.init_done = init_done_q;
  assign bus.sram_a    = sram_a_q;
  assign bus.sram_cen  = sram_cen_q;
  assign bus.sram_gwen = sram_gwen_q;
  assign bus.sram_wen  = sram_wen_q;
  assign bus.sram_d    = sram_d_q;

endmodule

// File: tb/tb_ct_l2c_data_sram_ctrl.sv
// Directed bench for ct_l2c_data_sram_ctrl with a behavioural SRAM and a read-response scoreboard.
module tb_ct_l2c_data_sram_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 128;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_l2c_data_sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ct_l2c_data_sram_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(LAT), .INIT_EN(1'b1)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst        (rst),
    .bus           (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  // Behavioural SRAM: garbage after reset, bit-masked writes, LAT-cycle read pipe
  logic [DW-1:0]  sram_mem [DEPTH];
  logic [DW-1:0]  pipe_d [LAT];
  logic [LAT-1:0] pipe_v;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] <= {$urandom, $urandom, $urandom, $urandom};
    end else if (!bus.sram_cen && !bus.sram_gwen) begin
      sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
    end
    pipe_d[0] <= sram_mem[bus.sram_a];
    pipe_v[0] <= !bus.sram_cen && bus.sram_gwen;
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_d[i] <= pipe_d[i-1];
      pipe_v[i] <= pipe_v[i-1];
    end
  end

  assign bus.sram_q = pipe_v[LAT-1] ? pipe_d[LAT-1] : {4{32'hDEADBEEF}};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (bus.rsp_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check1("rsp_unexpected", bus.rsp_vld, 1'b0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", bus.rsp_data, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 20 && bus.req_rdy !== 1'b1; i++) tick();
    check1("rdy_wait", bus.req_rdy, 1'b1);
  endtask

  task automatic reset_vals(input string tag);
    check1({tag, "_cen"}, bus.sram_cen, 1'b1);
    check1({tag, "_gwen"}, bus.sram_gwen, 1'b1);
    check({tag, "_wen"}, bus.sram_wen, '1);
    check({tag, "_a"}, DW'(bus.sram_a), '0);
    check({tag, "_d"}, bus.sram_d, '0);
    check1({tag, "_rdy"}, bus.req_rdy, 1'b0);
    check1({tag, "_rsp_vld"}, bus.rsp_vld, 1'b0);
    check({tag, "_rsp_data"}, bus.rsp_data, '0);
    check1({tag, "_init_done"}, bus.init_done, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    wait_rdy();
    bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = a;
    bus.req_wdata = d; bus.req_wmask = m;
    exp_mem[a] = (exp_mem[a] & ~m) | (d & m);
    tick();
    bus.req_vld = 1'b0;
    check1("wr_cen", bus.sram_cen, 1'b0);
    check1("wr_gwen", bus.sram_gwen, 1'b0);
    check("wr_wen", bus.sram_wen, ~m);
    check("wr_a", DW'(bus.sram_a), DW'(a));
    check("wr_d", bus.sram_d, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    wait_rdy();
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = a;
    exp_q.push_back(exp_mem[a]);
    tick();
    bus.req_vld = 1'b0;
    check1("rd_cen", bus.sram_cen, 1'b0);
    check1("rd_gwen", bus.sram_gwen, 1'b1);
    check("rd_wen", bus.sram_wen, '1);
    check("rd_a", DW'(bus.sram_a), DW'(a));
    check1("rd_rdy_low", bus.req_rdy, 1'b0);
  endtask

  task automatic init_sweep();
    for (int k = 1; k <= int'(DEPTH); k++) begin
      tick();
      check("init_a", DW'(bus.sram_a), DW'(k - 1));
      check1("init_cen", bus.sram_cen, 1'b0);
      check1("init_gwen", bus.sram_gwen, 1'b0);
      check("init_wen", bus.sram_wen, '0);
      check("init_d", bus.sram_d, '0);
      check1("init_rdy", bus.req_rdy, 1'b0);
      check1("init_done_early", bus.init_done, 1'b0);
    end
    tick();
    check1("init_done", bus.init_done, 1'b1);
    check1("init_rdy_up", bus.req_rdy, 1'b1);
    check1("init_cen_idle", bus.sram_cen, 1'b1);
  endtask

  logic [AW-1:0] ra;
  logic [DW-1:0] rd_data, rm;

  initial begin
    bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0;
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;

    // Reset values, then full init sweep released in cycle 0
    repeat (3) tick();
    reset_vals("rst");
    rst = 1'b0;
    init_sweep();
    for (int i = 0; i < int'(DEPTH); i++) rd(AW'(i));

    // Back-to-back writes
    wr(4'h3, {16{8'hA5}}, '1);
    wr(4'h4, {16{8'h5A}}, '1);
    tick();
    check1("b2b_cen_release", bus.sram_cen, 1'b1);
    rd(4'h3);
    rd(4'h4);

    // Masked and zero-mask writes
    wr(4'h7, '1, '1);
    wr(4'h7, '0, 128'hFF);
    rd(4'h7);
    wr(4'h7, '0, '0);
    rd(4'h7);

    // Read latency shape with RD_LAT=3
    rd(4'h4);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check1("lat_rdy_low", bus.req_rdy, 1'b0);
      check1("lat_rsp_quiet", bus.rsp_vld, 1'b0);
      check1("lat_cen_idle", bus.sram_cen, 1'b1);
    end
    tick();
    check1("lat_rsp_vld", bus.rsp_vld, 1'b1);
    check1("lat_rdy_back", bus.req_rdy, 1'b1);
    check("lat_rsp_data", bus.rsp_data, {16{8'h5A}});
    tick();
    check1("lat_rsp_pulse", bus.rsp_vld, 1'b0);
    check("lat_rsp_hold", bus.rsp_data, {16{8'h5A}});

    // Held request: write waits behind an in-flight read
    wait_rdy();
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 4'h3;
    exp_q.push_back(exp_mem[4'h3]);
    tick();
    bus.req_wr = 1'b1; bus.req_addr = 4'h5;
    bus.req_wdata = {4{32'h1234_5678}}; bus.req_wmask = '1;
    for (int k = 1; k <= 4; k++) begin
      check1("held_rdy_low", bus.req_rdy, 1'b0);
      if (k >= 2) check1("held_no_issue", bus.sram_cen, 1'b1);
      tick();
    end
    check1("held_rdy_up", bus.req_rdy, 1'b1);
    check1("held_rsp_vld", bus.rsp_vld, 1'b1);
    exp_mem[4'h5] = {4{32'h1234_5678}};
    tick();
    bus.req_vld = 1'b0;
    check1("held_wr_cen", bus.sram_cen, 1'b0);
    check1("held_wr_gwen", bus.sram_gwen, 1'b0);
    check("held_wr_a", DW'(bus.sram_a), DW'(4'h5));
    check("held_wr_d", bus.sram_d, {4{32'h1234_5678}});
    rd(4'h5);

    // Short random write/read mix
    repeat (6) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      rm = {$urandom, $urandom, $urandom, $urandom};
      wr(ra, rd_data, rm);
      rd(ra);
    end
    wait_rdy();

    // Reset while a read is in flight: response dropped, init restarts
    rd(4'h2);
    tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset_vals("rst_mid_rd");
    rst = 1'b0;
    tick();
    check("reinit_a0", DW'(bus.sram_a), '0);
    check1("reinit_cen0", bus.sram_cen, 1'b0);
    tick();
    check("reinit_a1", DW'(bus.sram_a), DW'(1));
    check1("reinit_rsp_quiet", bus.rsp_vld, 1'b0);

    // Reset again partway through init
    repeat (3) tick();
    rst = 1'b1;
    tick();
    reset_vals("rst_mid_init");
    rst = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
    init_sweep();
    rd(4'h3);
    rd(4'h7);
    rd(4'h5);
    wait_rdy();
    tick();
    check("sb_drain", DW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
